// File: rtl/wb_cmd_master_pkg.sv
// wb_cmd_master_pkg: shared status codes and FSM state encoding for wb_cmd_master.
//   status_e : completion status reported on the response port
//   state_e  : command FSM states
package wb_cmd_master_pkg;
    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_ERR     = 2'd1,
        ST_RTY_EXH = 2'd2,
        ST_TIMEOUT = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS     = 2'd1,
        BACKOFF = 2'd2,
        RESP    = 2'd3
    } state_e;
endpackage

// File: rtl/wb_cmd_timeout.sv
// wb_cmd_timeout: loadable down-counter that flags expiry while enabled.
//   clk_i/rst_i  : clock, asynchronous active-high reset
//   load_i       : load load_val_i (takes precedence over counting)
//   en_i         : count down while high
//   load_val_i   : reload value (cycles-1 until expiry)
//   expire_o     : high while enabled and the count has reached zero
module wb_cmd_timeout #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_cnt <= '0;
        else if (load_i)
            r_cnt <= load_val_i;
        else if (en_i && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign expire_o = en_i && (r_cnt == '0);
endmodule

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: valid/ready command port to Wishbone classic single-cycle initiator.
//   clk_i, rst_i                     : clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o          : command handshake (ready only when idle)
//   cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i : command fields, latched on accept
//   rsp_valid_o/rsp_ready_i          : response handshake
//   rsp_dat_o, rsp_status_o          : read data (0 unless OK read), status code
//   wb_adr_o..wb_stb_o               : Wishbone master outputs
//   wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i : Wishbone responder inputs
// Optional feature: define WB_CMD_MASTER_TIMEOUT_EN to abort a bus phase after
// TIMEOUT_CYC cycles without termination (status TIMEOUT).
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [AW-1:0]   cmd_adr_i,
    input  logic [DW-1:0]   cmd_dat_i,
    input  logic [DW/8-1:0] cmd_sel_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_dat_o,
    output logic [1:0]      rsp_status_o,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic            wb_rty_i
);
    if (MAX_RETRY < 0 || MAX_RETRY > 15 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("wb_cmd_master: MAX_RETRY must be 0..15 and TIMEOUT_CYC >= 1");
    end

    state_e          r_state, w_next;
    logic [AW-1:0]   r_adr;
    logic [DW-1:0]   r_dat;
    logic [DW/8-1:0] r_sel;
    logic            r_we;
    logic [3:0]      r_retry, w_retry_nx;
    logic [DW-1:0]   r_rsp_dat, w_rsp_dat;
    status_e         r_rsp_status, w_status;
    logic            w_accept, w_done, w_expire;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic w_load;
    // Reload on every entry into BUS, including the reissue after BACKOFF.
    assign w_load = w_accept || (r_state == BACKOFF);
    wb_cmd_timeout #(.W(TW)) u_timeout (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (w_load),
        .en_i       (r_state == BUS),
        .load_val_i (TW'(TIMEOUT_CYC - 1)),
        .expire_o   (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_done     = 1'b0;
        w_status   = ST_OK;
        w_rsp_dat  = '0;
        w_retry_nx = r_retry;
        case (r_state)
            IDLE: begin
                if (cmd_valid_i) begin
                    w_next   = BUS;
                    w_accept = 1'b1;
                end
            end
            BUS: begin
                // ERR outranks ACK, which outranks RTY; a termination outranks timeout.
                if (wb_err_i) begin
                    w_next   = RESP;
                    w_done   = 1'b1;
                    w_status = ST_ERR;
                end else if (wb_ack_i) begin
                    w_next    = RESP;
                    w_done    = 1'b1;
                    w_rsp_dat = r_we ? '0 : wb_dat_i;
                end else if (wb_rty_i) begin
                    if (r_retry < 4'(MAX_RETRY)) begin
                        w_next     = BACKOFF;
                        w_retry_nx = r_retry + 4'd1;
                    end else begin
                        w_next   = RESP;
                        w_done   = 1'b1;
                        w_status = ST_RTY_EXH;
                    end
                end else if (w_expire) begin
                    w_next   = RESP;
                    w_done   = 1'b1;
                    w_status = ST_TIMEOUT;
                end
            end
            BACKOFF: w_next = BUS;
            RESP: begin
                if (rsp_ready_i) begin
                    w_next     = IDLE;
                    w_retry_nx = '0;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_adr        <= '0;
            r_dat        <= '0;
            r_sel        <= '0;
            r_we         <= 1'b0;
            r_retry      <= '0;
            r_rsp_dat    <= '0;
            r_rsp_status <= ST_OK;
        end else begin
            r_state <= w_next;
            r_retry <= w_retry_nx;
            if (w_accept) begin
                r_adr <= cmd_adr_i;
                r_dat <= cmd_dat_i;
                r_sel <= cmd_sel_i;
                r_we  <= cmd_we_i;
            end
            if (w_done) begin
                r_rsp_dat    <= w_rsp_dat;
                r_rsp_status <= w_status;
            end
        end
    end

    // Outputs decode straight from the state register so reset drops cyc/stb immediately.
    assign cmd_ready_o  = (r_state == IDLE);
    assign rsp_valid_o  = (r_state == RESP);
    assign wb_cyc_o     = (r_state == BUS);
    assign wb_stb_o     = (r_state == BUS);
    assign wb_adr_o     = r_adr;
    assign wb_dat_o     = r_dat;
    assign wb_sel_o     = r_sel;
    assign wb_we_o      = r_we;
    assign rsp_dat_o    = r_rsp_dat;
    assign rsp_status_o = r_rsp_status;
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed bench for wb_cmd_master with a scripted responder and a
// per-cycle expected-trace model derived from each command's termination script.
module tb_wb_cmd_master;
    localparam int MAX_RETRY = 3;
    localparam int TO        = 8;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int NHOLD = TO_EN ? 3 : 110;
    localparam int T_SIL = 0, T_ACK = 1, T_ERR = 2, T_RTY = 3, T_EA = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [31:0] cmd_adr_i, cmd_dat_i;
    logic [3:0]  cmd_sel_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic [1:0]  rsp_status_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic        wb_ack_i, wb_err_i, wb_rty_i;

    wb_cmd_master #(.AW(32), .DW(32), .MAX_RETRY(MAX_RETRY), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o(rsp_dat_o), .rsp_status_o(rsp_status_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          bus;
        bit          resp;
        bit          idle;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        bit          we;
        logic [31:0] rdat;
        logic [1:0]  st;
    } exp_t;

    exp_t        exp_q[$];
    int          sw[$];
    int          stt[$];
    int          ra, rc;
    bit          stray;
    logic [31:0] rd_val;
    int          n_vec, n_err, obs_stb;
    logic [31:0] obs_dat;
    logic [1:0]  obs_st;

    assign wb_dat_i = rd_val;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Responder: terminates attempt ra after sw[ra] wait cycles with stt[ra];
    // while stb is low it optionally drives all terminations, which must be ignored.
    initial begin
        ra = 0; rc = 0;
        wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
        forever begin
            @(negedge clk_i);
            wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
            if (rst_i) begin
                ra = 0; rc = 0;
            end else if (wb_stb_o) begin
                if (ra < sw.size() && stt[ra] != T_SIL && rc == sw[ra]) begin
                    wb_ack_i = (stt[ra] == T_ACK || stt[ra] == T_EA);
                    wb_err_i = (stt[ra] == T_ERR || stt[ra] == T_EA);
                    wb_rty_i = (stt[ra] == T_RTY);
                    ra++; rc = 0;
                end else begin
                    rc++;
                end
            end else if (stray) begin
                wb_ack_i = 1; wb_err_i = 1; wb_rty_i = 1;
            end
        end
    end

    // Compare process: one expected-trace entry per cycle after each accept edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i); #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cyc", wb_cyc_o, e.bus);
                chk("stb", wb_stb_o, e.bus);
                chk("cmd_ready", cmd_ready_o, e.idle);
                chk("rsp_valid", rsp_valid_o, e.resp);
                if (e.bus) begin
                    obs_stb++;
                    chk("wb_adr", wb_adr_o, e.adr);
                    chk("wb_dat", wb_dat_o, e.dat);
                    chk("wb_sel", wb_sel_o, e.sel);
                    chk("wb_we", wb_we_o, e.we);
                end
                if (e.resp) begin
                    obs_dat = rsp_dat_o;
                    obs_st  = rsp_status_o;
                    chk("rsp_dat", rsp_dat_o, e.rdat);
                    chk("rsp_status", rsp_status_o, e.st);
                end
            end
        end
    end

    // Builds the expected cycle trace from the script, then drives the command and
    // rsp_ready along that trace. Called and returns at the negedge of an idle cycle.
    task automatic run_cmd(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] rd, input int hold);
        exp_t        e;
        bit          drv[$];
        int          retries, len;
        bit          done;
        logic [1:0]  st;
        logic [31:0] rdat;
        retries = 0; done = 0; st = 0; rdat = 0;
        rd_val = rd; ra = 0; rc = 0; obs_stb = 0;
        e = '{default: '0};
        e.adr = adr; e.dat = dat; e.sel = sel; e.we = we;
        for (int i = 0; i < sw.size() && !done; i++) begin
            len = (stt[i] == T_SIL) ? TO : sw[i] + 1;
            e.bus = 1;
            repeat (len) begin exp_q.push_back(e); drv.push_back(0); end
            e.bus = 0;
            case (stt[i])
                T_ACK: begin done = 1; rdat = we ? 32'h0 : rd; end
                T_ERR, T_EA: begin done = 1; st = 2'd1; end
                T_RTY: begin
                    if (retries < MAX_RETRY) begin
                        retries++;
                        exp_q.push_back(e); drv.push_back(0);
                    end else begin
                        done = 1; st = 2'd2;
                    end
                end
                default: begin done = 1; st = 2'd3; end
            endcase
        end
        e.resp = 1; e.rdat = rdat; e.st = st;
        for (int k = 0; k <= hold; k++) begin exp_q.push_back(e); drv.push_back(k == hold); end
        e.resp = 0; e.idle = 1;
        exp_q.push_back(e); drv.push_back(0);
        cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
        cmd_valid_i = 1; rsp_ready_i = 0;
        foreach (drv[k]) begin
            @(negedge clk_i);
            cmd_valid_i = 0;
            rsp_ready_i = drv[k];
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; obs_stb = 0; obs_dat = 0; obs_st = 0;
        stray = 0; rd_val = 0;
        cmd_valid_i = 0; cmd_we_i = 0; cmd_adr_i = 0; cmd_dat_i = 0; cmd_sel_i = 0;
        rsp_ready_i = 0;
        rst_i = 1;
        repeat (2) @(negedge clk_i);
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_wb_adr", wb_adr_o, 0);
        chk("rst_rsp_status", rsp_status_o, 0);
        rst_i = 0;
        @(negedge clk_i);

        sw = '{0}; stt = '{T_ACK};
        run_cmd(0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0);
        chk("t1_dat", obs_dat, 32'hDEADBEEF);
        chk("t1_status", obs_st, 0);
        chk("t1_stb_cycles", obs_stb, 1);

        sw = '{4}; stt = '{T_ACK};
        run_cmd(1, 32'h0, 32'h000000A5, 4'h1, 32'hCAFEF00D, 0);
        chk("t2_dat", obs_dat, 0);
        chk("t2_stb_cycles", obs_stb, 5);

        stray = 1;
        sw = '{0, 0, 0}; stt = '{T_RTY, T_RTY, T_ACK};
        run_cmd(0, 32'h20, 32'h0, 4'hF, 32'h11223344, 0);
        chk("t3_status", obs_st, 0);
        chk("t3_stb_cycles", obs_stb, 3);

        sw = '{0, 0, 0, 0}; stt = '{T_RTY, T_RTY, T_RTY, T_RTY};
        run_cmd(1, 32'h24, 32'h55, 4'h3, 32'h0, 0);
        chk("t3b_status", obs_st, 2);
        chk("t3b_stb_cycles", obs_stb, 4);

        sw = '{2}; stt = '{T_EA};
        run_cmd(0, 32'h30, 32'h0, 4'hF, 32'h99999999, 10);
        chk("t4_status", obs_st, 1);
        chk("t4_dat", obs_dat, 0);
        stray = 0;

        if (TO_EN) begin
            sw = '{0}; stt = '{T_SIL};
            run_cmd(0, 32'h40, 32'h0, 4'hF, 32'h0, 0);
            chk("t5_status", obs_st, 3);
            chk("t5_stb_cycles", obs_stb, TO);
        end

        sw = '{0}; stt = '{T_SIL}; ra = 0; rc = 0;
        cmd_we_i = 0; cmd_adr_i = 32'h50; cmd_sel_i = 4'hF; cmd_valid_i = 1;
        @(negedge clk_i);
        cmd_valid_i = 0;
        repeat (NHOLD) begin
            @(negedge clk_i);
            chk("cyc_held", wb_cyc_o, 1);
        end
        #3 rst_i = 1;
        #1;
        chk("t6_async_cyc", wb_cyc_o, 0);
        chk("t6_async_stb", wb_stb_o, 0);
        chk("t6_rsp_valid", rsp_valid_o, 0);
        chk("t6_cmd_ready", cmd_ready_o, 1);
        @(negedge clk_i);
        rst_i = 0;
        repeat (3) begin
            @(negedge clk_i);
            chk("t6_no_rsp", rsp_valid_o, 0);
            chk("t6_idle", cmd_ready_o, 1);
        end
        sw = '{1}; stt = '{T_ACK};
        run_cmd(0, 32'h44, 32'h0, 4'hF, 32'h12345678, 0);
        chk("t6_after_dat", obs_dat, 32'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
